float_ci_unit: RTL and testbench

FLOAT_CI_UNIT -- requirements
Module: float_ci_unit

---
 rtl/float_ci_pkg.sv | 61 ++++++
 rtl/lzc32.sv | 15 +
 rtl/float_ci_unit.sv | 97 +++++++++
 tb/tb_float_ci_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/float_ci_pkg.sv
// Shared opcodes, FSM state type and float helpers for the float custom-instruction unit.
package float_ci_pkg;

  localparam logic [2:0] OP_FMUL = 3'd0;
  localparam logic [2:0] OP_I2F  = 3'd1;
  localparam logic [2:0] OP_F2I  = 3'd2;
  localparam logic [2:0] OP_PASS = 3'd3;

  localparam logic [31:0] FP_INF  = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, EXEC, NORM, DONE} state_t;

  // Finishes a single-precision multiply from the raw 24x24 mantissa product (truncating).
  function automatic logic [31:0] fmul_pack(input logic [31:0] a, input logic [31:0] b,
                                            input logic [47:0] prod);
    logic              sgn;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic signed [10:0] e;
    logic [22:0]       m;
    sgn    = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != '0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != '0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == '0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == '0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
    if (prod[47]) begin
      m = prod[46:24];
      e = e + 11'sd1;
    end else begin
      m = prod[45:23];
    end
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return FP_QNAN;
    if (a_inf || b_inf) return FP_INF | {sgn, 31'b0};
    if (a_zero || b_zero || (e <= 11'sd0)) return {sgn, 31'b0};
    if (e >= 11'sd255) return FP_INF | {sgn, 31'b0};
    return {sgn, e[7:0], m};
  endfunction

  function automatic logic [31:0] i2f_pack(input logic sgn, input logic [31:0] mag,
                                           input logic [5:0] lz);
    logic [31:0] norm;
    logic [7:0]  e;
    if (mag == '0) return '0;
    norm = mag << lz;
    e    = 8'd158 - {2'b00, lz};
    return {sgn, e, norm[30:8]};
  endfunction

  function automatic logic [31:0] f2i(input logic [31:0] a);
    logic [31:0] mag;
    if ((a[30:23] == 8'hFF) && (a[22:0] != '0)) return '0;
    if (a[30:23] < 8'd127) return '0;
    if (a[30:23] >= 8'd158) return a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    mag = {1'b1, a[22:0], 8'h00} >> (8'd158 - a[30:23]);
    return a[31] ? (~mag + 32'd1) : mag;
  endfunction

endpackage

// File: rtl/lzc32.sv
// 32-bit leading-zero counter; an all-zero input reports 32.
module lzc32 (
  input  logic [31:0] data,
  output logic [5:0]  count
);

  always_comb begin
    count = 6'd32;
    // Ascending scan: the last hit is the most significant set bit.
    for (int unsigned i = 0; i < 32; i++) begin
      if (data[i]) count = 6'(31 - i);
    end
  end

endmodule

// File: rtl/float_ci_unit.sv
// Multi-cycle float custom instruction: FMUL, I2F, F2I, PASS with fixed start-to-done latency.
module float_ci_unit
  import float_ci_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        s2_clk_en,
  input  logic        s2_start,
  input  logic [2:0]  s2_n,
  input  logic [31:0] s2_dataa,
  input  logic [31:0] s2_datab,
  output logic        s2_done,
  output logic [31:0] s2_result
);

  // EXEC absorbs any latency beyond the three mandatory stages.
  localparam logic [15:0] EXEC_LAST = (LATENCY > 3) ? 16'(LATENCY - 3) : 16'd0;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [47:0] prod_q;
  logic [31:0] res_q;
  logic [31:0] res_next;
  logic [31:0] i2f_mag;
  logic [5:0]  i2f_lz;
  logic [23:0] man_a, man_b;

  assign man_a   = {1'b1, a_q[22:0]};
  assign man_b   = {1'b1, b_q[22:0]};
  assign i2f_mag = a_q[31] ? (~a_q + 32'd1) : a_q;

  lzc32 u_lzc (
    .data  (i2f_mag),
    .count (i2f_lz)
  );

  always_comb begin
    res_next = '0;
    case (op_q)
      OP_FMUL: res_next = fmul_pack(a_q, b_q, prod_q);
      OP_I2F:  res_next = i2f_pack(a_q[31], i2f_mag, i2f_lz);
      OP_F2I:  res_next = f2i(a_q);
      OP_PASS: res_next = a_q;
      default: res_next = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      res_q     <= '0;
      s2_done   <= 1'b0;
      s2_result <= '0;
    end else if (!s2_clk_en) begin
      // Done is a strobe: it never survives into a stalled cycle.
      s2_done <= 1'b0;
    end else begin
      s2_done <= 1'b0;
      case (state)
        IDLE: begin
          if (s2_start) begin
            op_q  <= s2_n;
            a_q   <= s2_dataa;
            b_q   <= s2_datab;
            cnt   <= '0;
            state <= EXEC;
          end
        end
        EXEC: begin
          prod_q <= 48'(man_a) * 48'(man_b);
          if (cnt == EXEC_LAST) state <= NORM;
          else cnt <= cnt + 16'd1;
        end
        NORM: begin
          res_q <= res_next;
          state <= DONE;
        end
        DONE: begin
          s2_result <= res_q;
          s2_done   <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_ci_unit.sv
// Directed scoreboard bench for float_ci_unit: expected result and done cycle queued at each start.
module tb_float_ci_unit;

  localparam int unsigned LAT = 3;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
    int unsigned id;
  } exp_t;

  logic        CLK;
  logic        RESET;
  logic        s2_clk_en;
  logic        s2_start;
  logic [2:0]  s2_n;
  logic [31:0] s2_dataa;
  logic [31:0] s2_datab;
  logic        s2_done;
  logic [31:0] s2_result;

  exp_t        sb[$];
  int unsigned cyc       = 0;
  int unsigned errors    = 0;
  int unsigned checks    = 0;
  int unsigned n_done    = 0;
  int unsigned exp_dones = 0;
  int unsigned op_id     = 0;

  float_ci_unit #(.LATENCY(LAT)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .s2_clk_en (s2_clk_en),
    .s2_start  (s2_start),
    .s2_n      (s2_n),
    .s2_dataa  (s2_dataa),
    .s2_datab  (s2_datab),
    .s2_done   (s2_done),
    .s2_result (s2_result)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Output monitor: samples 1 ns after each rising edge.
  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (s2_done === 1'b1) begin
      n_done++;
      checks++;
      assert (sb.size() > 0)
      else begin
        errors++;
        $error("FAIL unexpected_done cyc=%0d result=%h required=no done", cyc, s2_result);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        assert (s2_result === e.res)
        else begin
          errors++;
          $error("FAIL result op%0d got=%h required=%h", e.id, s2_result, e.res);
        end
        checks++;
        assert (cyc === e.cyc)
        else begin
          errors++;
          $error("FAIL done_cycle op%0d got=%0d required=%0d", e.id, cyc, e.cyc);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s got=%h required=%h", tag, got, want);
    end
  endtask

  // Called just after a falling edge; the start is taken on the next rising edge.
  task automatic issue(input logic [2:0] n, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] want, input int unsigned extra);
    exp_t e;
    s2_start = 1'b1;
    s2_n     = n;
    s2_dataa = a;
    s2_datab = b;
    e.res = want;
    e.cyc = cyc + 1 + LAT + extra;
    e.id  = op_id;
    op_id++;
    sb.push_back(e);
    exp_dones++;
    @(negedge CLK);
    s2_start = 1'b0;
  endtask

  task automatic wait_dones(input int unsigned want);
    int unsigned n = 0;
    while (n_done < want && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    assert (n_done >= want)
    else begin
      errors++;
      $error("FAIL done_timeout got=%0d dones required=%0d", n_done, want);
    end
  endtask

  task automatic run(input logic [2:0] n, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] want);
    issue(n, a, b, want, 0);
    wait_dones(exp_dones);
  endtask

  initial begin
    RESET     = 1'b1;
    s2_clk_en = 1'b1;
    s2_start  = 1'b0;
    s2_n      = '0;
    s2_dataa  = '0;
    s2_datab  = '0;
    repeat (3) @(negedge CLK);
    check("reset_done", {31'b0, s2_done}, 32'd0);
    check("reset_result", s2_result, 32'h0000_0000);
    RESET = 1'b0;

    // FMUL: normal, signed, overflow, denormal flush, NaN, 0*inf, signed zero, underflow
    run(3'd0, 32'h4000_0000, 32'h3FC0_0000, 32'h4040_0000);
    run(3'd0, 32'h3F00_0000, 32'hC040_0000, 32'hBFC0_0000);
    run(3'd0, 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000);
    run(3'd0, 32'h0000_0001, 32'h4000_0000, 32'h0000_0000);
    run(3'd0, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
    run(3'd0, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000);
    run(3'd0, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000);
    run(3'd0, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
    run(3'd0, 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);

    // I2F (operand B deliberately non-zero)
    run(3'd1, 32'h0000_03E8, 32'hFFFF_FFFF, 32'h447A_0000);
    run(3'd1, 32'h8000_0000, 32'h1234_5678, 32'hCF00_0000);
    run(3'd1, 32'h0000_0000, 32'hAAAA_AAAA, 32'h0000_0000);
    run(3'd1, 32'hFFFF_FFFF, 32'h0000_0000, 32'hBF80_0000);
    run(3'd1, 32'h0100_0001, 32'h0000_0000, 32'h4B80_0000);

    // F2I
    run(3'd2, 32'hC070_0000, 32'h4000_0000, 32'hFFFF_FFFD);
    run(3'd2, 32'h4F80_0000, 32'h0000_0000, 32'h7FFF_FFFF);
    run(3'd2, 32'hCF80_0000, 32'h0000_0000, 32'h8000_0000);
    run(3'd2, 32'h3F00_0000, 32'h0000_0000, 32'h0000_0000);
    run(3'd2, 32'h7FC0_0000, 32'h0000_0000, 32'h0000_0000);
    run(3'd2, 32'h42F6_0000, 32'h0000_0000, 32'h0000_007B);

    // PASS and undefined opcodes
    run(3'd5, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000);
    run(3'd7, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000);
    run(3'd3, 32'h1234_5678, 32'h8765_4321, 32'h1234_5678);

    // Busy start ignored, then back-to-back start in the cycle after done
    issue(3'd0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 0);
    s2_start = 1'b1;
    s2_n     = 3'd3;
    s2_dataa = 32'hCAFE_F00D;
    @(negedge CLK);
    s2_start = 1'b0;
    wait_dones(exp_dones);
    run(3'd1, 32'h0000_03E8, 32'h0000_0000, 32'h447A_0000);

    // Two-cycle stall right after acceptance stretches latency by two
    run(3'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678);
    issue(3'd0, 32'h4000_0000, 32'h3FC0_0000, 32'h4040_0000, 2);
    s2_clk_en = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      check("stall_result_hold", s2_result, 32'h1234_5678);
      check("stall_done_low", {31'b0, s2_done}, 32'd0);
    end
    s2_clk_en = 1'b1;
    wait_dones(exp_dones);

    // Reset two cycles into an FMUL aborts it; start right after reset is taken
    s2_start = 1'b1;
    s2_n     = 3'd0;
    s2_dataa = 32'h4000_0000;
    s2_datab = 32'h4000_0000;
    @(negedge CLK);
    s2_start = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("abort_result", s2_result, 32'h0000_0000);
    check("abort_done", {31'b0, s2_done}, 32'd0);
    run(3'd0, 32'h3F00_0000, 32'hC040_0000, 32'hBFC0_0000);

    repeat (8) @(negedge CLK);
    check("total_dones", n_done, exp_dones);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
